// File: rtl/exec_stage_param.sv
// Execute stage: ALU, branch resolution and the {N,C,Z} flag register, one op per cycle.
// Define EXEC_STAGE_MUL_EN to build the multi-cycle shift-add MUL; without it, code 11 is a NOP.
module exec_stage_param #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             alu_src,
    input  logic             branch,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic             branch_taken,
    output logic [2:0]       flags
);

    localparam int FN = 2;
    localparam int FC = 1;
    localparam int FZ = 0;
    localparam logic [WIDTH:0] ONE_W = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        OP_NOP = 4'd0, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_INC, OP_DEC,
        OP_SHL, OP_SHR, OP_MOV, OP_MUL, OP_SETC, OP_CLRC
    } alu_op_e;

    typedef enum logic [1:0] {BR_JZ, BR_JN, BR_JC, BR_JMP} br_cond_e;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;

    logic [WIDTH-1:0]   result_q, result_d;
    logic [2:0]         flags_q, flags_d;
    logic               valid_q, valid_d;
    logic               taken_q, taken_d;

    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH:0]     wide;
    logic               carry;
    logic               upd_nz;

    assign op_a   = alu_src ? imm : read_data1;
    assign op_b   = read_data2;
    assign shamt  = op_b[SHAMT_W-1:0];
    assign accept = in_valid & in_ready;

`ifdef EXEC_STAGE_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               mul_start;
    logic               mul_done;

    assign mul_start = accept & ~branch & (func == OP_MUL);
    assign in_ready  = ~rst & (state_q == S_IDLE);

    // One multiplier bit per cycle: add the shifted multiplicand when the current LSB is set.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        mul_done  = 1'b0;
        prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            S_IDLE: begin
                if (mul_start) begin
                    state_d  = S_MUL;
                    cnt_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, op_a};
                    mplier_d = op_b;
                    prod_d   = '0;
                end
            end
            S_MUL: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_d == CNT_W'(WIDTH)) begin
                    mul_done = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end
`else
    assign in_ready = ~rst;
`endif

    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        valid_d  = 1'b0;
        taken_d  = taken_q;
        alu_res  = '0;
        wide     = '0;
        carry    = flags_q[FC];
        upd_nz   = 1'b0;
        if (accept) begin
            valid_d  = 1'b1;
            taken_d  = 1'b0;
            result_d = '0;
            if (branch) begin
                // A taken conditional branch consumes the flag it tested.
                case (func[1:0])
                    BR_JZ: if (flags_q[FZ]) begin taken_d = 1'b1; flags_d[FZ] = 1'b0; end
                    BR_JN: if (flags_q[FN]) begin taken_d = 1'b1; flags_d[FN] = 1'b0; end
                    BR_JC: if (flags_q[FC]) begin taken_d = 1'b1; flags_d[FC] = 1'b0; end
                    default: taken_d = 1'b1;
                endcase
            end else begin
                case (func)
                    OP_ADD: begin
                        wide = {1'b0, op_a} + {1'b0, op_b};
                        alu_res = wide[WIDTH-1:0]; carry = wide[WIDTH]; upd_nz = 1'b1;
                    end
                    OP_SUB: begin
                        wide = {1'b0, op_a} - {1'b0, op_b};
                        alu_res = wide[WIDTH-1:0]; carry = wide[WIDTH]; upd_nz = 1'b1;
                    end
                    OP_AND: begin alu_res = op_a & op_b; upd_nz = 1'b1; end
                    OP_OR:  begin alu_res = op_a | op_b; upd_nz = 1'b1; end
                    OP_NOT: begin alu_res = ~op_a;       upd_nz = 1'b1; end
                    OP_INC: begin
                        wide = {1'b0, op_a} + ONE_W;
                        alu_res = wide[WIDTH-1:0]; carry = wide[WIDTH]; upd_nz = 1'b1;
                    end
                    OP_DEC: begin
                        wide = {1'b0, op_a} - ONE_W;
                        alu_res = wide[WIDTH-1:0]; carry = wide[WIDTH]; upd_nz = 1'b1;
                    end
                    OP_SHL: begin
                        wide = {1'b0, op_a} << shamt;
                        alu_res = wide[WIDTH-1:0]; upd_nz = 1'b1;
                        if (shamt != '0) carry = wide[WIDTH];
                    end
                    OP_SHR: begin
                        wide = {op_a, 1'b0} >> shamt;
                        alu_res = wide[WIDTH:1]; upd_nz = 1'b1;
                        if (shamt != '0) carry = wide[0];
                    end
                    OP_MOV: begin alu_res = op_a; upd_nz = 1'b1; end
                    OP_MUL: begin
`ifdef EXEC_STAGE_MUL_EN
                        valid_d = 1'b0;
`endif
                    end
                    OP_SETC: carry = 1'b1;
                    OP_CLRC: carry = 1'b0;
                    default: ;
                endcase
                flags_d[FC] = carry;
                if (upd_nz) begin
                    result_d    = alu_res;
                    flags_d[FN] = alu_res[WIDTH-1];
                    flags_d[FZ] = (alu_res == '0);
                end
            end
        end
`ifdef EXEC_STAGE_MUL_EN
        if (mul_done) begin
            valid_d  = 1'b1;
            taken_d  = 1'b0;
            result_d = prod_step[WIDTH-1:0];
            flags_d  = {prod_step[WIDTH-1], |prod_step[2*WIDTH-1:WIDTH],
                        (prod_step[WIDTH-1:0] == '0)};
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
            taken_q  <= taken_d;
        end
    end

    assign out_valid    = valid_q;
    assign alu_result   = result_q;
    assign branch_taken = taken_q;
    assign flags        = flags_q;

endmodule
